mem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the data memory's single access path (read port plus byte/half/word write port).
- Port 0 is instruction fetch; port 1 is load/store. Both share one memory port.
- Round-robin grant, registered request capture, one-cycle memory access phase, registered response with a per-port valid pulse.
- Rejects out-of-range addresses and illegal access modes without touching memory.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one memory port; gnt is combinational,
// memory access follows one cycle later and rvalid/rdata one cycle after that; requests simply wait while BUSY.
module mem_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [2:0]        mode0,
   input  logic [2:0]        mode1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [31:0]       rdata,
   output logic              err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_mode,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        mode_q, mode_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;

   logic can_grant, win0, win1, mode_ok, legal;

   // reset also masks grants so every output reads 0 while it is held
   assign can_grant = (state_q != BUSY) && !reset;
   assign win0      = can_grant && req0 && (!req1 || last_q);
   assign win1      = can_grant && req1 && (!req0 || !last_q);

   always_comb begin
      mode_ok = 1'b0;
      case (mode_q)
         3'b000, 3'b001, 3'b010: mode_ok = 1'b1;
         3'b100, 3'b101:         mode_ok = !we_q;
         default:                mode_ok = 1'b0;
      endcase
   end

   assign legal = mode_ok && ({1'b0, addr_q} < DEPTH_W);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      port_d    = port_q;
      we_d      = we_q;
      addr_d    = addr_q;
      mode_d    = mode_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      case (state_q)
         BUSY: begin
            state_d   = DONE;
            rdata_d   = (legal && !we_q) ? mem_rdata : 32'h0;
            err_d     = !legal;
            rvalid0_d = !port_q;
            rvalid1_d = port_q;
         end
         default: begin
            if (win0 || win1) begin
               state_d = BUSY;
               port_d  = win1;
               last_d  = win1;
               we_d    = win1 ? we1    : we0;
               addr_d  = win1 ? addr1  : addr0;
               mode_d  = win1 ? mode1  : mode0;
               wdata_d = win1 ? wdata1 : wdata0;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         port_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         mode_q    <= 3'b000;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         port_q    <= port_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         mode_q    <= mode_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   assign gnt0      = win0;
   assign gnt1      = win1;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   // the latched fields only change on a grant, so they hold through DONE
   assign mem_we    = (state_q == BUSY) && we_q && legal;
   assign mem_addr  = addr_q;
   assign mem_mode  = mode_q;
   assign mem_wdata = wdata_q;

endmodule
